// File: rtl/timer_arbiter_if.sv
// Signal bundle between the timer arbiter, its four requesters and the timer peripheral bus.
// The arbiter takes the master modport; requesters and the timer side take the slave modport.
interface timer_arbiter_if;
  logic [3:0]  req;
  logic [15:0] delay0;
  logic [15:0] delay1;
  logic [15:0] delay2;
  logic [15:0] delay3;
  logic        timer_done;
  logic [3:0]  grant;
  logic [3:0]  done;
  logic        busy;
  logic        bus_write;
  logic [15:0] bus_id;
  logic [15:0] bus_din;

  modport master (
    input  req, delay0, delay1, delay2, delay3, timer_done,
    output grant, done, busy, bus_write, bus_id, bus_din
  );

  modport slave (
    output req, delay0, delay1, delay2, delay3, timer_done,
    input  grant, done, busy, bus_write, bus_id, bus_din
  );
endinterface

// File: rtl/timer_arbiter.sv
// Round-robin arbiter that shares one down-counting timer among four requesters.
// A winner's delay is written to the timer (upper half zero first), then done is returned on expiry.
module timer_arbiter #(
  parameter logic [15:0] LOWER_ID = 16'h0010,
  parameter logic [15:0] UPPER_ID = 16'h0011
) (
  input  logic            clk,
  input  logic            reset,
  timer_arbiter_if.master arb
);

  typedef enum logic [2:0] {IDLE, WR_HI, WR_LO, WAIT, DONE} state_t;

  state_t      state_q, state_d;
  logic [1:0]  ptr_q, ptr_d;
  logic [1:0]  idx_q, idx_d;
  logic [15:0] dly_q, dly_d;
  logic [3:0]  grant_q, grant_d;
  logic [3:0]  done_q, done_d;
  logic        busy_q, busy_d;
  logic        bus_write_q, bus_write_d;
  logic [15:0] bus_id_q, bus_id_d;
  logic [15:0] bus_din_q, bus_din_d;

  logic [1:0]  winner;
  logic [1:0]  cand;
  logic [15:0] winner_dly;

  // Scan from the farthest position down so the nearest set bit after ptr wins.
  always_comb begin
    winner = ptr_q;
    cand   = ptr_q;
    for (int k = 4; k >= 1; k--) begin
      cand = ptr_q + 2'(k);
      if (arb.req[cand]) winner = cand;
    end
  end

  always_comb begin
    case (winner)
      2'd0:    winner_dly = arb.delay0;
      2'd1:    winner_dly = arb.delay1;
      2'd2:    winner_dly = arb.delay2;
      default: winner_dly = arb.delay3;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    idx_d       = idx_q;
    dly_d       = dly_q;
    grant_d     = 4'b0000;
    done_d      = 4'b0000;
    busy_d      = 1'b0;
    bus_write_d = 1'b0;
    bus_id_d    = 16'h0000;
    bus_din_d   = 16'h0000;

    case (state_q)
      IDLE: begin
        if (arb.req != 4'b0000) begin
          idx_d   = winner;
          dly_d   = winner_dly;
          state_d = (winner_dly == 16'h0000) ? DONE : WR_HI;
        end
      end
      WR_HI: state_d = WR_LO;
      WR_LO: state_d = WAIT;
      WAIT: begin
        if (arb.timer_done) state_d = DONE;
      end
      DONE: begin
        ptr_d   = idx_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are registered, so they are derived from the state being entered.
    if (state_d != IDLE) begin
      busy_d  = 1'b1;
      grant_d = 4'b0001 << idx_d;
    end
    if (state_d == DONE) done_d = 4'b0001 << idx_d;
    if (state_d == WR_HI) begin
      bus_write_d = 1'b1;
      bus_id_d    = UPPER_ID;
    end
    if (state_d == WR_LO) begin
      bus_write_d = 1'b1;
      bus_id_d    = LOWER_ID;
      bus_din_d   = dly_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      ptr_q       <= 2'd3;
      idx_q       <= 2'd0;
      dly_q       <= 16'h0000;
      grant_q     <= 4'b0000;
      done_q      <= 4'b0000;
      busy_q      <= 1'b0;
      bus_write_q <= 1'b0;
      bus_id_q    <= 16'h0000;
      bus_din_q   <= 16'h0000;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      idx_q       <= idx_d;
      dly_q       <= dly_d;
      grant_q     <= grant_d;
      done_q      <= done_d;
      busy_q      <= busy_d;
      bus_write_q <= bus_write_d;
      bus_id_q    <= bus_id_d;
      bus_din_q   <= bus_din_d;
    end
  end

  assign arb.grant     = grant_q;
  assign arb.done      = done_q;
  assign arb.busy      = busy_q;
  assign arb.bus_write = bus_write_q;
  assign arb.bus_id    = bus_id_q;
  assign arb.bus_din   = bus_din_q;

endmodule

// File: doc/timer_arbiter.md
# timer_arbiter

Round-robin scheduler that shares the single 32-bit down-counting timer peripheral (bus ids 0x0010/0x0011, one-cycle `dout` expiry strobe) among four requesters. Each requester asks for a 16-bit delay. The arbiter grants one requester at a time, programs the timer over the peripheral write bus, waits for the expiry strobe, then returns a one-cycle `done` to that requester. It is the only writer of the timer ids; any CPU path to those ids is removed when this block is instantiated.

## Interface
- `LOWER_ID`, 16'h0010, timer low-half register id
- `UPPER_ID`, 16'h0011, timer high-half register id
- `clk`  in  1  system clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high; same reset drives the timer peripheral
- `req`  in  4  level request per requester; held until its `done`
- `delay0`..`delay3`  in  16 each  requested delay in clocks, sampled only at grant
- `timer_done`  in  1  timer expiry strobe (timer `dout`)
- `grant`  out  4  one-hot, high from grant through the `done` cycle
- `done`  out  4  one-cycle completion pulse to the granted requester
- `busy`  out  1  high in every state except IDLE
- `bus_write`  out  1  timer register write strobe
- `bus_id`  out  16  timer register id
- `bus_din`  out  16  timer register data

## Operation
- All outputs are registered. Reset values: `grant`=0, `done`=0, `busy`=0, `bus_write`=0, `bus_id`=0, `bus_din`=0, state=IDLE, `ptr`=3, latched index=0, latched delay=0.
- State machine:
  - IDLE: if `req`≠0, pick the winner and latch its index and delay. Otherwise stay in IDLE.
    - Winner is the first set bit in the order ptr+1, ptr+2, ptr+3, ptr (mod 4).
    - Latched delay = 0: go to DONE directly with no bus writes.
    - Latched delay ≠ 0: go to WR_HI.
  - WR_HI: `bus_write`=1, `bus_id`=UPPER_ID, `bus_din`=0. Go to WR_LO.
  - WR_LO: `bus_write`=1, `bus_id`=LOWER_ID, `bus_din`=latched delay. Go to WAIT.
  - WAIT: hold until `timer_done`=1, then go to DONE.
  - DONE: `done[idx]`=1 and `grant[idx]`=1 for exactly one cycle. Then `ptr`←idx and go to IDLE.
- Upper half is always written as 0 and written first. The timer ignores a half-write while it is counting above 1, so 32-bit delays are not supported.
- `bus_write`, `bus_id` and `bus_din` are all 0 outside WR_HI and WR_LO.
- `timer_done` is ignored outside WAIT.
- Changes on `req` or `delayN` after grant are ignored; the latched values rule.
- A requester whose `req` is still high in IDLE after its `done` is re-served if it wins arbitration. Requesters drop `req` on the edge that samples `done`.
- Reset mid-operation: all state and outputs return to reset values on the next edge. No `done` is issued. The timer is cleared by the same reset.

## Timing
- Edge E0: IDLE samples `req`. Grant, latch and WR_HI bus signals are visible after E0.
- Timer samples the upper write at E1 and the lower write at E2. Timer holds D after E2.
- `timer_done` is high in the cycle after E2+D. The arbiter samples it at E2+D+1.
- `done` and the final `grant` cycle fall in the cycle after E2+D+1, so `done` is D+3 cycles after grant.
- Delay 0: `grant` and `done` are both high in the cycle after E0 (1-cycle latency). No timer access.
- Grant drops one edge after `done`. IDLE then needs one cycle before the next grant, so back-to-back services are separated by exactly one IDLE cycle.

## Test plan
- Reset, then `req`=0001 with `delay0`=5 -> writes (0x0011,0x0000) then (0x0010,0x0005) on consecutive cycles; `done[0]` pulses 8 cycles after the grant edge; `busy` low afterward.
- `req`=1111, all delays 2 -> service order 0,1,2,3, then 0 again if held; exactly one `grant` bit high at any time; one IDLE cycle between services.
- `req[2]` with `delay2`=0 -> `grant[2]` and `done[2]` high together one cycle after request; no `bus_write` at all.
- Inject `timer_done` pulses during IDLE, WR_HI and WR_LO -> no state change; `done` only after the real expiry.
- `delay1`=1 -> `done[1]` 4 cycles after grant; change `delay1` to 100 during WAIT -> no effect.
- Assert `reset` during WAIT with `delay0`=50 -> all outputs 0 next cycle; no `done`; next `req`=1000 is granted first with `ptr`=3.
